// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one word read in flight,
// buffers one returned instruction and drives the IF/ID register for decode.
module fetch_stage #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0]  NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD,
  output logic [6:0]      opD,
  output logic [2:0]      funct3D,
  output logic            funct7b5D,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state, state_n;
  logic [XLEN-1:0] pcf, pcf_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] buf_instr, buf_instr_n;
  logic [XLEN-1:0] buf_pc, buf_pc_n;
  logic            kill, kill_n;
  logic            issue;
  logic            load_d;
  logic [XLEN-1:0] load_instr, load_pc;
  logic [XLEN-1:0] target;

  // Redirect targets are forced word-aligned before they reach the PC.
  assign target = {PCTargetE[XLEN-1:2], 2'b00};

  // Request handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // once valid is raised, addr stays put until it transfers unless stallF or a redirect withdraws it.
  // Responses carry no ready: imem_rsp_valid is a one-cycle pulse that must be consumed that cycle.
  assign imem_req_valid = issue;
  assign imem_req_addr  = pcf;
  assign dbg_state      = state;

  always_comb begin
    state_n     = state;
    pcf_n       = pcf;
    fetch_pc_n  = fetch_pc;
    kill_n      = kill;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    issue       = 1'b0;
    load_d      = 1'b0;
    load_instr  = buf_instr;
    load_pc     = buf_pc;
    case (state)
      S_REQ: begin
        issue = !stallF && !PCSrcE;
        if (PCSrcE) begin
          pcf_n = target;
        end else if (issue && imem_req_ready) begin
          fetch_pc_n = pcf;
          pcf_n      = pcf + FOUR;
          kill_n     = 1'b0;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill || PCSrcE) begin
            if (PCSrcE) pcf_n = target;
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else if (!stallD) begin
            load_d     = 1'b1;
            load_instr = imem_rsp_data;
            load_pc    = fetch_pc;
            state_n    = S_REQ;
          end else begin
            buf_instr_n = imem_rsp_data;
            buf_pc_n    = fetch_pc;
            state_n     = S_FULL;
          end
        end else if (PCSrcE) begin
          // Response still owed by memory; remember to throw it away.
          pcf_n  = target;
          kill_n = 1'b1;
        end
      end
      S_FULL: begin
        if (PCSrcE) begin
          pcf_n   = target;
          state_n = S_REQ;
        end else if (!stallD) begin
          load_d  = 1'b1;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pcf       <= RESET_PC;
      fetch_pc  <= '0;
      kill      <= 1'b0;
      buf_instr <= NOP;
      buf_pc    <= '0;
    end else begin
      state     <= state_n;
      pcf       <= pcf_n;
      fetch_pc  <= fetch_pc_n;
      kill      <= kill_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
    end
  end

  // IF/ID: flush beats stall beats a delivered instruction; otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (reset || flushD) begin
      InstrD <= NOP;
      PCD    <= '0;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (load_d) begin
        InstrD <= load_instr;
        PCD    <= load_pc;
        validD <= 1'b1;
      end else begin
        InstrD <= NOP;
        PCD    <= '0;
        validD <= 1'b0;
      end
    end
  end

  assign PCPlus4D  = PCD + FOUR;
  assign opD       = InstrD[6:0];
  assign funct3D   = InstrD[14:12];
  assign funct7b5D = InstrD[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-programmable instruction memory plus an in-order
// scoreboard of the (pc, instr) pairs that must appear in IF/ID.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        validD;
  logic [6:0]  opD;
  logic [2:0]  funct3D;
  logic        funct7b5D;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // memory model controls
  int          lat = 1;
  int          issue_limit = 0;
  int          issued = 0;
  logic        ready_en = 1'b0;
  logic        acc_s = 1'b0, rst_s = 1'b0, pend = 1'b0;
  logic [31:0] acc_addr = '0, paddr = '0;
  int          cnt = 0;
  logic        stalld_edge = 1'b0, rst_edge = 1'b1;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD),
    .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D), .dbg_state(dbg_state)
  );

  assign imem_req_ready = ready_en && (issued < issue_limit);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0020_8133;
      default:       mem_word = (a ^ 32'h5A5A_0000) | 32'h0000_0003;
    endcase
  endfunction

  // ---------------- memory model ----------------
  always @(negedge clk) begin
    acc_s    = !reset && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    rst_s    = reset;
  end

  always @(posedge clk) begin
    stalld_edge = stallD;
    rst_edge    = reset;
    #1;
    imem_rsp_valid = 1'b0;
    if (rst_s) begin
      pend   = 1'b0;
      issued = 0;
    end else begin
      if (acc_s) begin
        pend   = 1'b1;
        paddr  = acc_addr;
        cnt    = lat;
        issued = issued + 1;
      end
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
          pend           = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_edge) begin
      if (validD && !stalld_edge) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery: PCD=%h InstrD=%h, expected no instruction", PCD, InstrD);
        end else begin
          e = exp_q.pop_front();
          if (PCD !== e[63:32] || InstrD !== e[31:0] || PCPlus4D !== e[63:32] + 32'd4 ||
              opD !== e[6:0] || funct3D !== e[14:12] || funct7b5D !== e[30]) begin
            errors++;
            $display("FAIL ifid_delivery: PCD=%h InstrD=%h PCPlus4D=%h op=%h f3=%h f7b5=%b, expected pc=%h instr=%h",
                     PCD, InstrD, PCPlus4D, opD, funct3D, funct7b5D, e[63:32], e[31:0]);
          end
        end
      end else if (!validD) begin
        checks++;
        if (InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h4) begin
          errors++;
          $display("FAIL ifid_bubble: InstrD=%h PCD=%h PCPlus4D=%h, expected %h/0/4", InstrD, PCD, PCPlus4D, NOP);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ready_en = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = '0; issue_limit = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d instructions never delivered, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (validD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h4) begin
      errors++;
      $display("FAIL reset_ifid: validD=%b InstrD=%h PCD=%h PCPlus4D=%h, expected 0/%h/0/4", validD, InstrD, PCD, PCPlus4D, NOP);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_req: valid=%b addr=%h state=%0d, expected 1/0/0", imem_req_valid, imem_req_addr, dbg_state);
    end
    stallF = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_stallf_gate: valid=%b, expected 0", imem_req_valid);
    end
    stallF = 1'b0; PCSrcE = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_redirect_gate: valid=%b, expected 0", imem_req_valid);
    end
    PCSrcE = 1'b0;
  endtask

  task automatic test_basic();
    int first, second, seen;
    do_reset();
    lat = 1; issue_limit = 2; ready_en = 1'b1;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    exp_q.push_back({32'h4, mem_word(32'h4)});
    first = -1; second = -1; seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (validD) begin
        if (seen == 0) begin
          first = i;
          checks++;
          if (PCD !== 32'h0 || InstrD !== 32'h0050_0093 || opD !== 7'h13 || funct3D !== 3'd0 || funct7b5D !== 1'b0) begin
            errors++;
            $display("FAIL basic_first: PCD=%h InstrD=%h op=%h, expected 0/00500093/13", PCD, InstrD, opD);
          end
        end else begin
          second = i;
          checks++;
          if (PCD !== 32'h4 || InstrD !== 32'h0020_8133 || opD !== 7'h33 || funct3D !== 3'd0 || funct7b5D !== 1'b0) begin
            errors++;
            $display("FAIL basic_second: PCD=%h InstrD=%h op=%h, expected 4/00208133/33", PCD, InstrD, opD);
          end
        end
        seen++;
      end
    end
    checks++;
    if (seen != 2 || second - first != 2) begin
      errors++;
      $display("FAIL basic_rate: seen=%0d spacing=%0d, expected 2 deliveries 2 cycles apart", seen, second - first);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      errors++;
      $display("FAIL basic_next_req: valid=%b addr=%h, expected 1/00000008", imem_req_valid, imem_req_addr);
    end
    drain_and_check("basic");
  endtask

  task automatic test_stall_buffer();
    do_reset();
    lat = 1; issue_limit = 1; ready_en = 1'b1; stallD = 1'b1;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== 2'd2 || imem_req_valid !== 1'b0 || validD !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: state=%0d req_valid=%b validD=%b, expected 2/0/0", dbg_state, imem_req_valid, validD);
      end
      tick();
    end
    stallD = 1'b0;
    @(negedge clk);
    checks++;
    if (validD !== 1'b0) begin
      errors++;
      $display("FAIL stall_release_latency: validD=%b, expected 0 until next edge", validD);
    end
    @(negedge clk);
    checks++;
    if (validD !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      errors++;
      $display("FAIL stall_release: validD=%b req_valid=%b addr=%h, expected 1/1/00000004", validD, imem_req_valid, imem_req_addr);
    end
    drain_and_check("stall");
  endtask

  task automatic test_redirect_wait();
    logic ok;
    do_reset();
    lat = 3; issue_limit = 3; ready_en = 1'b1;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    exp_q.push_back({32'h4, mem_word(32'h4)});
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (issued == 3) ok = 1'b1;
    end
    checks++;
    if (!ok || dbg_state !== 2'd1 || imem_req_addr !== 32'hC) begin
      errors++;
      $display("FAIL redirect_setup: reached=%b state=%0d pcf=%h, expected WAIT for 0x8", ok, dbg_state, imem_req_addr);
    end
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0101;
    tick();
    PCSrcE = 1'b0;
    exp_q.push_back({32'h100, mem_word(32'h100)});
    issue_limit = 4;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (imem_req_valid) ok = 1'b1;
    end
    checks++;
    if (!ok || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_addr: seen=%b addr=%h, expected 00000100", ok, imem_req_addr);
    end
    drain_and_check("redirect");
  endtask

  task automatic test_redirect_flush();
    logic ok;
    do_reset();
    lat = 1; issue_limit = 2; ready_en = 1'b1;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (validD) ok = 1'b1;
    end
    stallD = 1'b1;
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0200; flushD = 1'b1; stallD = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || imem_rsp_valid !== 1'b1 || validD !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: delivered=%b rsp=%b validD=%b, expected 1/1/1", ok, imem_rsp_valid, validD);
    end
    tick();
    PCSrcE = 1'b0; flushD = 1'b0;
    @(negedge clk);
    checks++;
    if (validD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL flush_result: validD=%b InstrD=%h req=%b addr=%h, expected 0/%h/1/00000200",
               validD, InstrD, imem_req_valid, imem_req_addr, NOP);
    end
    drain_and_check("flush");
  endtask

  task automatic test_ready_stallf();
    logic [5:0] pat;
    pat = 6'b111010;
    do_reset();
    lat = 1; issue_limit = 1;
    for (int i = 0; i < 6; i++) begin
      stallF = pat[i];
      ready_en = (i >= 4);
      @(negedge clk);
      checks++;
      if (imem_req_valid !== !pat[i] || imem_req_addr !== 32'h0) begin
        errors++;
        $display("FAIL stallf_cycle%0d: valid=%b addr=%h, expected %b/0", i, imem_req_valid, imem_req_addr, !pat[i]);
      end
      tick();
    end
    checks++;
    if (issued !== 0) begin
      errors++;
      $display("FAIL stallf_no_issue: issued=%0d, expected 0", issued);
    end
    stallF = 1'b0;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    drain_and_check("stallf");
  endtask

  task automatic test_wrap_reset();
    logic ok;
    do_reset();
    lat = 1; issue_limit = 2; ready_en = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    tick();
    PCSrcE = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (validD) ok = 1'b1;
    end
    stallD = 1'b1;
    checks++;
    if (!ok || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pcplus4: PCD=%h PCPlus4D=%h, expected FFFFFFFC/00000000", PCD, PCPlus4D);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next_addr: valid=%b addr=%h, expected 1/00000000", imem_req_valid, imem_req_addr);
    end
    lat = 4;
    tick();
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd1 || validD !== 1'b1) begin
      errors++;
      $display("FAIL wrap_wait: state=%0d validD=%b, expected 1/1", dbg_state, validD);
    end
    ready_en = 1'b0; reset = 1'b1; stallD = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (validD !== 1'b0 || dbg_state !== 2'd0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL midwait_reset: validD=%b state=%0d req=%b addr=%h, expected 0/0/1/00000000",
               validD, dbg_state, imem_req_valid, imem_req_addr);
    end
    drain_and_check("wrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_buffer();
    test_redirect_wait();
    test_redirect_flush();
    test_ready_stallf();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
